// File: rtl/ov5640_dvp_gen.sv
// DVP frame generator: turns a 16-bit RGB565 pixel stream into OV5640-style
// vsync/href/8-bit byte-bus frames, high byte first, two clocks per pixel.
module ov5640_dvp_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 64,
  parameter int unsigned VS_LEN   = 16,
  parameter int unsigned V_BACK   = 32,
  parameter int unsigned V_FRONT  = 32
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        gen_en,
  input  logic [15:0] s_pix_data,
  input  logic        s_pix_valid,
  output logic        s_pix_req,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic [15:0] frame_cnt,
  output logic        underrun
);

  localparam int unsigned HLen = 2 * H_ACTIVE;
  localparam int unsigned M1   = (HLen > H_BLANK) ? HLen : H_BLANK;
  localparam int unsigned M2   = (M1 > VS_LEN) ? M1 : VS_LEN;
  localparam int unsigned M3   = (M2 > V_BACK) ? M2 : V_BACK;
  localparam int unsigned CntMax = (M3 > V_FRONT) ? M3 : V_FRONT;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned LineW  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [CntW-1:0]  VsLast   = CntW'(VS_LEN - 1);
  localparam logic [CntW-1:0]  VbLast   = CntW'(V_BACK - 1);
  localparam logic [CntW-1:0]  LineLast = CntW'(HLen - 1);
  localparam logic [CntW-1:0]  HbLast   = CntW'(H_BLANK - 1);
  localparam logic [CntW-1:0]  VfLast   = CntW'(V_FRONT - 1);
  localparam logic [LineW-1:0] LastLine = LineW'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    StIdle, StVsync, StVbp, StLine, StHblank, StVfp
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [LineW-1:0] line_q, line_d;
  logic             frame_done;
  logic             req_d;
  logic [15:0]      pix_q;

  // State, cycle and line counters.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  // Next-state: each state lasts a fixed number of clocks counted by cnt.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CntW'(1);
    line_d     = line_q;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (gen_en) state_d = StVsync;
      end
      StVsync: begin
        if (cnt_q == VsLast) begin
          state_d = StVbp;
          cnt_d   = '0;
        end
      end
      StVbp: begin
        if (cnt_q == VbLast) begin
          state_d = StLine;
          cnt_d   = '0;
          line_d  = '0;
        end
      end
      StLine: begin
        if (cnt_q == LineLast) begin
          state_d = (line_q == LastLine) ? StVfp : StHblank;
          cnt_d   = '0;
        end
      end
      StHblank: begin
        if (cnt_q == HbLast) begin
          state_d = StLine;
          cnt_d   = '0;
          line_d  = line_q + LineW'(1);
        end
      end
      StVfp: begin
        if (cnt_q == VfLast) begin
          state_d    = gen_en ? StVsync : StIdle;
          cnt_d      = '0;
          frame_done = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobe is registered, so it is decided from the state the next cycle will be in:
  // set when that cycle directly precedes a high-byte cycle.
  always_comb begin
    req_d = ((state_d == StVbp) && (cnt_d == VbLast)) ||
            ((state_d == StHblank) && (cnt_d == HbLast)) ||
            ((state_d == StLine) && cnt_d[0] && (cnt_d != LineLast));
  end

  // Pixel latch, sticky underrun, strobe register and frame counter.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      s_pix_req <= 1'b0;
      pix_q     <= '0;
      underrun  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      s_pix_req <= req_d;
      if (s_pix_req) begin
        pix_q <= s_pix_valid ? s_pix_data : 16'h0000;
        if (!s_pix_valid) underrun <= 1'b1;
      end
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Bus outputs decode directly from registered state; even LINE cycles carry the high byte.
  always_comb begin
    dvp_vsync = (state_q == StVsync);
    dvp_href  = (state_q == StLine);
    dvp_data  = 8'h00;
    if (state_q == StLine) dvp_data = cnt_q[0] ? pix_q[7:0] : pix_q[15:8];
  end

endmodule

// File: tb/tb_ov5640_dvp_gen.sv
// Randomized bench for ov5640_dvp_gen against a frame-position reference model.
module tb_ov5640_dvp_gen;

  localparam int HA = 4;
  localparam int VA = 3;
  localparam int HB = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VF = 2;
  localparam int P  = 2 * HA + HB;
  localparam int A  = VA * 2 * HA + (VA - 1) * HB;
  localparam int L  = VS + VB + A + VF;

  logic        sclk;
  logic        s_rst_n;
  logic        gen_en;
  logic [15:0] s_pix_data;
  logic        s_pix_valid;
  logic        s_pix_req;
  logic        dvp_vsync;
  logic        dvp_href;
  logic [7:0]  dvp_data;
  logic [15:0] frame_cnt;
  logic        underrun;

  int n_vec = 0;
  int n_err = 0;

  // Bench-side controls applied at the next cycle's drive point.
  logic gen_req  = 1'b0;
  int   valid_pct = 100;
  bit   do_reset = 1'b0;

  // Reference model: position within the frame, plus latched pixel and counters.
  bit          m_run;
  int          m_pos;
  logic [15:0] m_fc;
  logic        m_under;
  logic [15:0] m_pix;

  ov5640_dvp_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VS_LEN(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .sclk       (sclk),
    .s_rst_n    (s_rst_n),
    .gen_en     (gen_en),
    .s_pix_data (s_pix_data),
    .s_pix_valid(s_pix_valid),
    .s_pix_req  (s_pix_req),
    .dvp_vsync  (dvp_vsync),
    .dvp_href   (dvp_href),
    .dvp_data   (dvp_data),
    .frame_cnt  (frame_cnt),
    .underrun   (underrun)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // 0 = nothing on bus, 1 = vsync, 2 = high byte, 3 = low byte.
  function automatic int kind(input int p);
    int r;
    int o;
    if (p < VS) return 1;
    r = p - VS - VB;
    if (r < 0 || r >= A) return 0;
    o = r % P;
    if (o >= 2 * HA) return 0;
    return (o % 2 == 0) ? 2 : 3;
  endfunction

  function automatic bit exp_req();
    return m_run && (m_pos + 1 < L) && (kind(m_pos + 1) == 2);
  endfunction

  task automatic model_reset();
    m_run   = 1'b0;
    m_pos   = 0;
    m_fc    = '0;
    m_under = 1'b0;
    m_pix   = '0;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_vsync"}, {31'd0, dvp_vsync}, 32'd0);
    check({pfx, "_href"},  {31'd0, dvp_href},  32'd0);
    check({pfx, "_data"},  {24'd0, dvp_data},  32'd0);
    check({pfx, "_req"},   {31'd0, s_pix_req}, 32'd0);
    check({pfx, "_fcnt"},  {16'd0, frame_cnt}, 32'd0);
    check({pfx, "_under"}, {31'd0, underrun},  32'd0);
  endtask

  task automatic one_cycle();
    int k;
    logic [7:0] e_data;
    logic [15:0] nd;
    logic nv;
    @(negedge sclk);
    k = m_run ? kind(m_pos) : 0;
    e_data = (k == 2) ? m_pix[15:8] : (k == 3) ? m_pix[7:0] : 8'h00;
    check("vsync", {31'd0, dvp_vsync}, {31'd0, k == 1});
    check("href",  {31'd0, dvp_href},  {31'd0, k >= 2});
    check("data",  {24'd0, dvp_data},  {24'd0, e_data});
    check("req",   {31'd0, s_pix_req}, {31'd0, exp_req()});
    check("fcnt",  {16'd0, frame_cnt}, {16'd0, m_fc});
    check("under", {31'd0, underrun},  {31'd0, m_under});
    check("vs_href_excl", {31'd0, dvp_vsync & dvp_href}, 32'd0);
    check("req_vs_excl",  {31'd0, s_pix_req & dvp_vsync}, 32'd0);
    if (do_reset) begin
      #1 s_rst_n = 1'b0;
      #1 check_zero("async_rst");
      model_reset();
      #1 s_rst_n = 1'b1;
      do_reset = 1'b0;
    end
    gen_en = gen_req;
    nd = 16'($urandom);
    nv = ($urandom_range(99) < valid_pct);
    s_pix_data  = nd;
    s_pix_valid = nv;
    // Advance the model across the coming rising edge.
    if (exp_req()) begin
      m_pix = nv ? nd : 16'h0000;
      if (!nv) m_under = 1'b1;
    end
    if (!m_run) begin
      if (gen_en) begin
        m_run = 1'b1;
        m_pos = 0;
      end
    end else if (m_pos == L - 1) begin
      m_fc = m_fc + 16'd1;
      if (gen_en) m_pos = 0;
      else m_run = 1'b0;
    end else begin
      m_pos++;
    end
  endtask

  initial begin
    int guard;
    s_rst_n     = 1'b0;
    gen_en      = 1'b0;
    s_pix_data  = '0;
    s_pix_valid = 1'b0;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge sclk);
    s_rst_n = 1'b1;

    // Continuous frames, always-valid pixels.
    gen_req = 1'b1;
    valid_pct = 100;
    repeat (3 * L + 5) one_cycle();

    // Occasional missing pixels: zero bytes and sticky underrun.
    valid_pct = 80;
    repeat (3 * L) one_cycle();

    // Drop gen_en during line 1: frame completes, then idle.
    valid_pct = 100;
    guard = 0;
    while (!(m_run && m_pos >= VS + VB + P && m_pos < VS + VB + 2 * P) && guard < 4 * L) begin
      one_cycle();
      guard++;
    end
    check("line1_timeout", {31'd0, guard >= 4 * L}, 32'd0);
    gen_req = 1'b0;
    repeat (2 * L) one_cycle();
    check("idle_after_drop", {31'd0, m_run}, 32'd0);

    // Asynchronous reset pulse mid-line, then restart.
    gen_req = 1'b1;
    guard = 0;
    while (!(m_run && kind(m_pos) >= 2) && guard < 4 * L) begin
      one_cycle();
      guard++;
    end
    check("line_timeout", {31'd0, guard >= 4 * L}, 32'd0);
    do_reset = 1'b1;
    repeat (2 * L + 4) one_cycle();

    // Random gen_en toggling with mostly-valid pixels.
    valid_pct = 90;
    repeat (600) begin
      if ($urandom_range(49) == 0) gen_req = ~gen_req;
      one_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
